// File: rtl/pmem_loader.sv
// Byte-stream program loader: parses [N][N x 4 bytes MSB first][CHK],
// writes assembled words into pmem and releases the core only after a good checksum.
module pmem_loader #(
    parameter int unsigned PMEM_AW = 8,
    parameter int unsigned DW      = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [7:0]         s_data_i,
    input  logic               s_valid_i,
    output logic               s_ready_o,
    output logic               pmem_we_o,
    output logic [PMEM_AW-1:0] pmem_addr_o,
    output logic [DW-1:0]      pmem_wdata_o,
    output logic               core_rst_no,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o
);

    localparam int unsigned BW = 8;  // stream byte width
    localparam int unsigned CW = 8;  // word counter width (N is one byte)
    localparam int unsigned IW = 2;  // byte-in-word index width

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_DATA = 3'd2,
        S_CHK  = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_e;

    state_e               state_q,    state_d;
    logic [CW-1:0]        n_q,        n_d;
    logic [CW-1:0]        word_idx_q, word_idx_d;
    logic [IW-1:0]        byte_idx_q, byte_idx_d;
    logic [DW-1:0]        shift_q,    shift_d;
    logic [BW-1:0]        acc_q,      acc_d;
    logic                 we_q,       we_d;
    logic [PMEM_AW-1:0]   addr_q,     addr_d;
    logic [DW-1:0]        wdata_q,    wdata_d;
    logic                 active_q,   active_d;
    logic                 done_q,     done_d;
    logic                 err_q,      err_d;

    logic xfer;

    // A byte moves only when the loader is in a receiving state.
    assign xfer = s_valid_i && active_q;

    // State and datapath registers; everything clears on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            acc_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            acc_q      <= acc_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            active_q   <= active_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Next-state, frame parsing and registered-output decode.
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        acc_d      = acc_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_HDR;
            end
            S_HDR: begin
                if (xfer) begin
                    n_d        = s_data_i;
                    acc_d      = s_data_i;
                    word_idx_d = '0;
                    byte_idx_d = '0;
                    shift_d    = '0;
                    state_d    = (s_data_i == 8'd0) ? S_CHK : S_DATA;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    shift_d    = {shift_q[DW-BW-1:0], s_data_i};
                    acc_d      = acc_q ^ s_data_i;
                    byte_idx_d = byte_idx_q + IW'(1);
                    if (byte_idx_q == IW'(3)) begin
                        // Word complete: strobe it next cycle at the current index.
                        we_d       = 1'b1;
                        addr_d     = PMEM_AW'(word_idx_q);
                        wdata_d    = shift_d;
                        word_idx_d = word_idx_q + CW'(1);
                        if (word_idx_q == n_q - CW'(1)) state_d = S_CHK;
                    end
                end
            end
            S_CHK: begin
                if (xfer) state_d = (s_data_i == acc_q) ? S_DONE : S_ERR;
            end
            S_DONE, S_ERR: begin
                if (start_i) state_d = S_HDR;
            end
            default: state_d = S_IDLE;
        endcase

        // Status flags follow the state being entered so they change with it.
        active_d = (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_CHK);
        done_d   = (state_d == S_DONE);
        err_d    = (state_d == S_ERR);
    end

    assign s_ready_o    = active_q;
    assign busy_o       = active_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign core_rst_no  = done_q;
    assign pmem_we_o    = we_q;
    assign pmem_addr_o  = addr_q;
    assign pmem_wdata_o = wdata_q;

endmodule

// File: tb/tb_pmem_loader.sv
// Bench for pmem_loader: frame-level reference model, per-cycle compare, directed + random frames.
module tb_pmem_loader;

    localparam int AW = 4;   // small address space so long frames wrap
    localparam int DW = 32;
    localparam int M_IDLE = 0, M_LOAD = 1, M_DONE = 2, M_ERR = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          valid = 1'b0;
    logic [7:0]    data = 8'h00;
    logic          s_ready_o, pmem_we_o, core_rst_no, busy_o, done_o, err_o;
    logic [AW-1:0] pmem_addr_o;
    logic [DW-1:0] pmem_wdata_o;

    pmem_loader #(.PMEM_AW(AW), .DW(DW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start),
        .s_data_i(data), .s_valid_i(valid), .s_ready_o(s_ready_o),
        .pmem_we_o(pmem_we_o), .pmem_addr_o(pmem_addr_o), .pmem_wdata_o(pmem_wdata_o),
        .core_rst_no(core_rst_no), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks position within the frame and keeps every received byte.
    int            m_mode = M_IDLE;
    int            m_pos = 0;
    int            m_n = 0;
    logic [7:0]    m_bytes [0:1023];
    logic          m_we = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [31:0]   m_wdata = '0;

    function automatic logic [7:0] frame_xor(input int upto);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < upto; i++) x = x ^ m_bytes[i];
        return x;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode  <= M_IDLE;
            m_pos   <= 0;
            m_n     <= 0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
        end else begin
            m_we <= 1'b0;
            if (m_mode != M_LOAD) begin
                if (start) begin
                    m_mode <= M_LOAD;
                    m_pos  <= 0;
                end
            end else if (valid) begin
                m_bytes[m_pos] <= data;
                m_pos <= m_pos + 1;
                if (m_pos == 0) begin
                    m_n <= int'(data);
                end else if (m_pos <= 4 * m_n) begin
                    if (m_pos % 4 == 0) begin
                        m_we    <= 1'b1;
                        m_addr  <= AW'((m_pos / 4 - 1) % (1 << AW));
                        m_wdata <= {m_bytes[m_pos-3], m_bytes[m_pos-2], m_bytes[m_pos-1], data};
                    end
                end else begin
                    m_mode <= (frame_xor(m_pos) == data) ? M_DONE : M_ERR;
                end
            end
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        check("s_ready", s_ready_o, 32'(m_mode == M_LOAD));
        check("busy", busy_o, 32'(m_mode == M_LOAD));
        check("done", done_o, 32'(m_mode == M_DONE));
        check("err", err_o, 32'(m_mode == M_ERR));
        check("core_rst_n", core_rst_no, 32'(m_mode == M_DONE));
        check("pmem_we", pmem_we_o, 32'(m_we));
        check("pmem_addr", pmem_addr_o, 32'(m_addr));
        check("pmem_wdata", pmem_wdata_o, m_wdata);
    end

    // Observed pmem contents and write count.
    logic [31:0] dut_mem [0:(1<<AW)-1];
    int          wr_count = 0;
    always @(negedge clk) begin
        if (pmem_we_o) begin
            dut_mem[pmem_addr_o] <= pmem_wdata_o;
            wr_count <= wr_count + 1;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic noise(input int n);
        for (int i = 0; i < n; i++) begin
            valid = 1'b1;
            data  = 8'($urandom);
            @(negedge clk);
        end
        valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int mingap, input int maxgap);
        int g;
        bit ok;
        int t;
        g = (maxgap > mingap) ? int'($urandom_range(maxgap, mingap)) : mingap;
        for (int i = 0; i < g; i++) begin
            valid = 1'b0;
            data  = 8'($urandom);
            @(negedge clk);
        end
        valid = 1'b1;
        data  = b;
        ok = 1'b0;
        t = 0;
        while (!ok && t < 20) begin
            ok = (s_ready_o === 1'b1);
            @(negedge clk);
            t++;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL handshake_timeout: got no ready expected ready within 20 cycles");
        end
        valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] fr[$], input int mingap, input int maxgap,
                              input int mid_start);
        for (int i = 0; i < fr.size(); i++) begin
            if (i == mid_start) begin
                valid = 1'b0;
                pulse_start();
            end
            send_byte(fr[i], mingap, maxgap);
        end
        idle(2);
    endtask

    task automatic make_frame(input int n, input bit bad, output logic [7:0] fr[$]);
        logic [7:0] x;
        logic [7:0] b;
        fr = {};
        fr.push_back(8'(n));
        x = 8'(n);
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            fr.push_back(b);
            x = x ^ b;
        end
        fr.push_back(bad ? (x ^ 8'(1 + $urandom_range(254, 0))) : x);
    endtask

    logic [7:0] good_fr[$];
    logic [7:0] bad_fr[$];
    logic [7:0] empty_fr[$];
    logic [7:0] rnd_fr[$];
    int base;

    initial begin
        good_fr  = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'h88, 8'h00, 8'hA0, 8'h01, 8'h2A};
        bad_fr   = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'h88, 8'h00, 8'hA0, 8'h01, 8'h2B};
        empty_fr = '{8'h00, 8'h00};

        // Reset state
        idle(3);
        check("rst_ready", s_ready_o, 0);
        check("rst_we", pmem_we_o, 0);
        check("rst_core", core_rst_no, 0);
        check("rst_done", done_o, 0);
        check("rst_err", err_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_addr", pmem_addr_o, 0);
        check("rst_wdata", pmem_wdata_o, 0);
        rst_n = 1'b1;
        idle(2);

        // Bytes offered in IDLE are dropped
        noise(4);
        idle(1);

        // Good load
        base = wr_count;
        pulse_start();
        send_frame(good_fr, 0, 0, -1);
        check("good_done", done_o, 1);
        check("good_core", core_rst_no, 1);
        check("good_err", err_o, 0);
        check("good_writes", 32'(wr_count - base), 2);
        check("good_mem0", dut_mem[0], 32'h0000_0001);
        check("good_mem1", dut_mem[1], 32'h8800_A001);

        // Reload: flags drop and loader is ready the cycle after start
        pulse_start();
        check("reload_core", core_rst_no, 0);
        check("reload_done", done_o, 0);
        check("reload_busy", busy_o, 1);
        check("reload_ready", s_ready_o, 1);

        // Bad checksum (reuses the reload's HDR state)
        base = wr_count;
        send_frame(bad_fr, 0, 0, -1);
        check("bad_err", err_o, 1);
        check("bad_done", done_o, 0);
        check("bad_core", core_rst_no, 0);
        check("bad_writes", 32'(wr_count - base), 2);

        // Recovery after error
        pulse_start();
        send_frame(good_fr, 0, 0, -1);
        check("recover_done", done_o, 1);

        // Empty frame
        base = wr_count;
        pulse_start();
        send_frame(empty_fr, 0, 0, -1);
        check("empty_writes", 32'(wr_count - base), 0);
        check("empty_done", done_o, 1);
        check("empty_core", core_rst_no, 1);

        // Gaps, ignored bytes in DONE, start pulsed mid-DATA
        noise(3);
        base = wr_count;
        pulse_start();
        send_frame(good_fr, 1, 3, 6);
        check("bp_done", done_o, 1);
        check("bp_writes", 32'(wr_count - base), 2);

        // Reset after 3rd data byte
        pulse_start();
        for (int i = 0; i < 4; i++) send_byte(good_fr[i], 0, 0);
        base = wr_count;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ready", s_ready_o, 0);
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_we", pmem_we_o, 0);
        check("mid_rst_core", core_rst_no, 0);
        idle(3);
        rst_n = 1'b1;
        idle(2);
        check("mid_rst_writes", 32'(wr_count - base), 0);
        pulse_start();
        send_frame(good_fr, 0, 1, -1);
        check("post_rst_done", done_o, 1);
        check("post_rst_writes", 32'(wr_count - base), 2);

        // Address wrap: 20 words into a 16-word space
        base = wr_count;
        make_frame(20, 1'b0, rnd_fr);
        pulse_start();
        send_frame(rnd_fr, 0, 1, -1);
        check("wrap_done", done_o, 1);
        check("wrap_writes", 32'(wr_count - base), 20);

        // Random frames
        for (int k = 0; k < 14; k++) begin
            int n;
            bit bad;
            n   = int'($urandom_range(20, 0));
            bad = ($urandom_range(3, 0) == 0);
            make_frame(n, bad, rnd_fr);
            noise(int'($urandom_range(3, 0)));
            base = wr_count;
            pulse_start();
            send_frame(rnd_fr, 0, int'($urandom_range(2, 0)),
                       int'($urandom_range(4 * n + 3, 1)));
            check("rnd_done", done_o, 32'(!bad));
            check("rnd_err", err_o, 32'(bad));
            check("rnd_writes", 32'(wr_count - base), 32'(n));
        end

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pmem_loader.md
Name: pmem_loader

Overview:
- Byte-stream program loader for the micro: receives a framed byte stream (header, instruction words, checksum) over a valid/ready interface.
- Assembles 32-bit instruction words and writes them sequentially into pmem through its write port.
- Holds the core in reset until a load completes with a good checksum.
- Sits between the external link (UART/debug receiver) and the pmem write port plus the core reset input; it is the in-system replacement for the bench writing pmem directly.

Parameters:
- PMEM_AW, 8, pmem address width; max loadable words = min(255, 2^PMEM_AW).
- DW, 32, instruction word width; fixed at 4 bytes per word.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  begin a load (single-cycle pulse, level tolerated)
- s_data_i  in  8  stream byte
- s_valid_i  in  1  stream byte valid
- s_ready_o  out  1  loader accepts byte
- pmem_we_o  out  1  pmem write strobe, one cycle per word
- pmem_addr_o  out  PMEM_AW  pmem word address
- pmem_wdata_o  out  DW  instruction word
- core_rst_no  out  1  active-low reset to the core; 0 = core held
- busy_o  out  1  load in progress (HDR/DATA/CHK)
- done_o  out  1  last load succeeded
- err_o  out  1  last load checksum mismatch

Behaviour:
- Reset values:
  - All outputs are 0 under rst_ni=0 (including core_rst_no=0); FSM goes to IDLE.
  - Counters, assembled word and checksum accumulator clear.
  - Reset is asynchronous and active-low, with synchronous release.
- Handshake:
  - A byte is transferred on a cycle where s_valid_i && s_ready_o.
  - s_ready_o=1 only in HDR, DATA and CHK; otherwise bytes are ignored (not buffered).
  - s_ready_o does not depend combinationally on s_valid_i.
- Frame format: [N] [N x 4 bytes, MSB first] [CHK].
  - CHK = XOR of every byte of N and all data bytes.
- FSM:
  - IDLE: start_i -> HDR.
  - HDR: on transfer, N latched, accumulator = byte, word_idx=0, byte_idx=0. N=0 -> CHK; otherwise -> DATA.
  - DATA: each transfer shifts the byte in (first byte -> wdata[31:24]) and XORs it into the accumulator.
    - On the 4th byte of a word, pmem_we_o=1 in the following cycle, with pmem_addr_o=word_idx and pmem_wdata_o=assembled word.
    - word_idx then increments.
    - After word N-1's 4th byte -> CHK.
    - Write latency is exactly 1 cycle after the handshake. A byte of the next word may be accepted in the same cycle the write strobe is high.
  - CHK: on transfer, compare the byte with the accumulator. Match -> DONE, mismatch -> ERR.
  - DONE: done_o=1, core_rst_no=1; held until start_i.
  - ERR: err_o=1, core_rst_no=0; held until start_i.
  - start_i in DONE or ERR -> HDR. done_o, err_o and core_rst_no go to 0 on the cycle of entry to HDR.
  - start_i in HDR, DATA or CHK is ignored.
- Outputs:
  - pmem_addr_o and pmem_wdata_o hold their last values when pmem_we_o=0.
  - pmem_we_o is never high outside the cycle after a word completes.
- Boundaries:
  - Each load restarts at address 0.
  - If N > 2^PMEM_AW, the address wraps modulo 2^PMEM_AW; no error flag is raised for this.
  - Arbitrary gaps in s_valid_i are tolerated at any state.
  - Reset mid-load aborts immediately. Already-written pmem words remain; no further strobe is issued.
  - Words written before a checksum failure remain in pmem, but the core stays in reset.

Test Plan:
- Good load: start_i, bytes 02,00,00,00,01,88,00,A0,01,2A.
  - Required: pmem_we_o pulses at addr0=0x00000001 and addr1=0x8800A001, each 1 cycle after the 4th byte.
  - Then done_o=1 and core_rst_no=1; the core then executes NOP followed by MOVE r1,10.
- Bad checksum: same stream with CHK=2B.
  - Required: the same two writes occur, then err_o=1, done_o=0, core_rst_no=0.
  - A following start_i plus a correct frame gives done_o=1.
- Empty frame: start_i, bytes 00,00.
  - Required: no pmem_we_o pulse; done_o=1, core_rst_no=1.
- Backpressure and ignore:
  - Stimulus: bytes with s_valid_i asserted in IDLE; then the good frame sent with 1-3 idle cycles between bytes, plus start_i pulsed mid-DATA.
  - Required: IDLE bytes are dropped (s_ready_o=0), and the result is identical to the good-load case.
- Reset mid-load: assert rst_ni=0 after the 3rd data byte.
  - Required: all outputs are 0 immediately and no write occurs.
  - After release, a good load completes normally from addr0.
- Reload: after DONE, pulse start_i.
  - Required: the next cycle shows core_rst_no=0, done_o=0, busy_o=1, s_ready_o=1.
